md5_job_scheduler: RTL and testbench

- Keyspace scheduler that sits above NUM_ENGINES brute-force search engines; each engine is an MD5 core plus a candidate generator.
- Splits the host-programmed candidate-index range [cfgBase, cfgLimit) into chunks and hands them round-robin to idle engines.
- Collects done/match reports, latches the first matching index and broadcasts abort.
- Exposes status and a job counter to the host command decoder.

---
 rtl/md5_sched_pkg.sv | 24 ++
 rtl/md5_job_scheduler_rr_arbiter.sv | 31 +++
 rtl/md5_job_scheduler.sv | 180 ++++++++++++++++++
 tb/tb_md5_job_scheduler.sv | 353 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/md5_sched_pkg.sv
// Shared types for the MD5 keyspace scheduler: state encoding, default widths, host status word.
// Latency: none, declarations only.
// Backpressure: not applicable.
package md5_sched_pkg;

  localparam int IDX_W_DEF   = 64;
  localparam int CHUNK_W_DEF = 32;

  // Scheduler state encoding, as seen by the host on the 3-bit state output.
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_DISPATCH  = 3'd1,
    ST_DRAIN     = 3'd2,
    ST_MATCHED   = 3'd3,
    ST_EXHAUSTED = 3'd4
  } sched_state_e;

  // Host status word: state in [2:0], found in [3].
  typedef struct packed {
    logic         found;
    sched_state_e state;
  } sched_status_t;

endpackage

// File: rtl/md5_job_scheduler_rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester after i_ptr, wrapping modulo N.
// Latency: purely combinational.
// Backpressure: none; an all-zero request vector yields an all-zero grant.
module rr_arbiter #(
  parameter int N     = 4,
  parameter int PTR_W = $clog2(N)
) (
  input  logic [N-1:0]     i_req,
  input  logic [PTR_W-1:0] i_ptr,
  output logic [N-1:0]     o_gnt
);

  int w_dist;
  int w_best;

  // Pick the requester with the smallest distance past i_ptr (distance 0 is i_ptr+1).
  always_comb begin
    o_gnt  = '0;
    w_best = N;
    w_dist = 0;
    for (int i = 0; i < N; i++) begin
      w_dist = (i + N - 1 - int'(i_ptr)) % N;
      if (i_req[i] && (w_dist < w_best)) begin
        w_best   = w_dist;
        o_gnt    = '0;
        o_gnt[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/md5_job_scheduler.sv
// Keyspace scheduler: chunks [base, limit) into jobs, deals them round-robin to idle engines, latches first hit.
// Latency: first job strobe 2 cycles after start, then at most one job per cycle; done frees an engine for the next cycle.
// Backpressure: an engine is offered work only while its busy flag is clear; no job issues while all engines are busy.
module md5_job_scheduler
  import md5_sched_pkg::*;
#(
  parameter int NUM_ENGINES = 4,
  parameter int IDX_W       = IDX_W_DEF,
  parameter int CHUNK_W     = CHUNK_W_DEF
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [IDX_W-1:0]             cfgBase,
  input  logic [IDX_W-1:0]             cfgLimit,
  input  logic [CHUNK_W-1:0]           cfgChunk,
  input  logic                         start,
  input  logic                         hostAbort,
  output logic [NUM_ENGINES-1:0]       jobValid,
  output logic [IDX_W-1:0]             jobBase,
  output logic [CHUNK_W-1:0]           jobCount,
  input  logic [NUM_ENGINES-1:0]       engineDone,
  input  logic [NUM_ENGINES-1:0]       engineMatch,
  input  logic [NUM_ENGINES*IDX_W-1:0] engineMatchIdx,
  output logic                         abortAll,
  output logic [NUM_ENGINES-1:0]       busy,
  output logic [2:0]                   state,
  output logic                         found,
  output logic [IDX_W-1:0]             matchIndex,
  output logic [31:0]                  jobsIssued
);

  localparam int PTR_W = $clog2(NUM_ENGINES);

  sched_state_e           r_state;
  sched_state_e           w_state_nxt;
  logic [IDX_W-1:0]       r_next_idx;
  logic [IDX_W-1:0]       r_limit;
  logic [CHUNK_W-1:0]     r_chunk;
  logic [PTR_W-1:0]       r_rr_ptr;
  logic [NUM_ENGINES-1:0] r_busy;

  logic [NUM_ENGINES-1:0] w_gnt;
  logic [NUM_ENGINES-1:0] w_hit;
  logic [PTR_W-1:0]       w_gnt_idx;
  logic [IDX_W-1:0]       w_hit_idx;
  logic [IDX_W-1:0]       w_remain;
  logic [IDX_W-1:0]       w_chunk_ext;
  logic [IDX_W-1:0]       w_count;
  logic [IDX_W-1:0]       w_next_idx_inc;
  logic                   w_start_ok;
  logic                   w_abort;
  logic                   w_match;
  logic                   w_grant;

  // A hit only counts from an engine that actually holds a job.
  assign w_hit          = engineDone & engineMatch & r_busy;
  // The job size is clipped to what is left, so nextIdx lands exactly on limit and never wraps.
  assign w_remain       = r_limit - r_next_idx;
  assign w_chunk_ext    = IDX_W'(r_chunk);
  assign w_count        = (w_chunk_ext < w_remain) ? w_chunk_ext : w_remain;
  assign w_next_idx_inc = r_next_idx + w_count;

  assign busy  = r_busy;
  assign state = r_state;

  rr_arbiter #(
    .N     (NUM_ENGINES),
    .PTR_W (PTR_W)
  ) u_rr_arbiter (
    .i_req (~r_busy),
    .i_ptr (r_rr_ptr),
    .o_gnt (w_gnt)
  );

  // Encode the one-hot grant, and select the hit index of the lowest-numbered hitting engine.
  always_comb begin
    w_gnt_idx = '0;
    for (int i = 0; i < NUM_ENGINES; i++) begin
      if (w_gnt[i]) w_gnt_idx = PTR_W'(i);
    end
    w_hit_idx = '0;
    for (int i = NUM_ENGINES - 1; i >= 0; i--) begin
      if (w_hit[i]) w_hit_idx = engineMatchIdx[i*IDX_W +: IDX_W];
    end
  end

  // Next-state and action decode; host abort outranks a match, a match outranks a grant.
  always_comb begin
    w_state_nxt = r_state;
    w_start_ok  = 1'b0;
    w_abort     = 1'b0;
    w_match     = 1'b0;
    w_grant     = 1'b0;
    if (hostAbort && (r_state != ST_IDLE)) begin
      w_abort     = 1'b1;
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE, ST_MATCHED, ST_EXHAUSTED: begin
          if (start) begin
            w_start_ok  = 1'b1;
            w_state_nxt = (cfgBase >= cfgLimit) ? ST_EXHAUSTED : ST_DISPATCH;
          end
        end
        ST_DISPATCH: begin
          if (|w_hit) begin
            w_match     = 1'b1;
            w_state_nxt = ST_MATCHED;
          end else if (|w_gnt) begin
            w_grant = 1'b1;
            if (w_next_idx_inc == r_limit) w_state_nxt = ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (|w_hit) begin
            w_match     = 1'b1;
            w_state_nxt = ST_MATCHED;
          end else if (r_busy == '0) begin
            w_state_nxt = ST_EXHAUSTED;
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Datapath: search window, job strobes, engine busy tracking, hit latch and counters.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_next_idx <= '0;
      r_limit    <= '0;
      r_chunk    <= '0;
      r_rr_ptr   <= PTR_W'(NUM_ENGINES - 1);
      r_busy     <= '0;
      jobValid   <= '0;
      jobBase    <= '0;
      jobCount   <= '0;
      abortAll   <= 1'b0;
      found      <= 1'b0;
      matchIndex <= '0;
      jobsIssued <= '0;
    end else begin
      jobValid <= '0;
      abortAll <= 1'b0;
      r_busy   <= r_busy & ~engineDone;
      if (w_start_ok) begin
        r_next_idx <= cfgBase;
        r_limit    <= cfgLimit;
        r_chunk    <= (cfgChunk == '0) ? CHUNK_W'(1) : cfgChunk;
        found      <= 1'b0;
        matchIndex <= '0;
        jobsIssued <= '0;
      end
      if (w_grant) begin
        jobValid   <= w_gnt;
        jobBase    <= r_next_idx;
        jobCount   <= CHUNK_W'(w_count);
        r_busy     <= (r_busy & ~engineDone) | w_gnt;
        r_rr_ptr   <= w_gnt_idx;
        r_next_idx <= w_next_idx_inc;
        jobsIssued <= jobsIssued + 32'd1;
      end
      if (w_match) begin
        found      <= 1'b1;
        matchIndex <= w_hit_idx;
      end
      if (w_abort || w_match) begin
        abortAll <= 1'b1;
        r_busy   <= '0;
      end
    end
  end

endmodule

// File: tb/tb_md5_job_scheduler.sv
// Bench for md5_job_scheduler: directed scenarios plus randomized searches against a behavioural model.
// Latency: model advances once per clock and every output is compared 1 ns after each rising edge.
// Backpressure: emulated engines hold each job for a random 1..6 cycles before reporting done.
module tb_md5_job_scheduler;
  import md5_sched_pkg::*;

  localparam int N  = 4;
  localparam int IW = 64;
  localparam int CW = 32;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic [IW-1:0]   cfgBase = '0;
  logic [IW-1:0]   cfgLimit = '0;
  logic [CW-1:0]   cfgChunk = '0;
  logic            start = 1'b0;
  logic            hostAbort = 1'b0;
  logic [N-1:0]    jobValid;
  logic [IW-1:0]   jobBase;
  logic [CW-1:0]   jobCount;
  logic [N-1:0]    engineDone = '0;
  logic [N-1:0]    engineMatch = '0;
  logic [N*IW-1:0] engineMatchIdx = '0;
  logic            abortAll;
  logic [N-1:0]    busy;
  logic [2:0]      state;
  logic            found;
  logic [IW-1:0]   matchIndex;
  logic [31:0]     jobsIssued;

  md5_job_scheduler #(.NUM_ENGINES(N), .IDX_W(IW), .CHUNK_W(CW)) dut (
    .clk(clk), .reset_n(reset_n), .cfgBase(cfgBase), .cfgLimit(cfgLimit), .cfgChunk(cfgChunk),
    .start(start), .hostAbort(hostAbort), .jobValid(jobValid), .jobBase(jobBase), .jobCount(jobCount),
    .engineDone(engineDone), .engineMatch(engineMatch), .engineMatchIdx(engineMatchIdx),
    .abortAll(abortAll), .busy(busy), .state(state), .found(found), .matchIndex(matchIndex),
    .jobsIssued(jobsIssued)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int n_abort_seen = 0;

  typedef struct { logic [N-1:0] v; logic [IW-1:0] b; logic [CW-1:0] c; int t; } job_t;
  job_t jq[$];

  // behavioural model of the scheduler
  int            m_state;
  bit            m_busy [N];
  int            m_rr;
  logic [IW-1:0] m_next, m_limit, m_chunk, m_midx, m_jb;
  logic [CW-1:0] m_jc;
  logic [31:0]   m_jobs;
  bit            m_found, m_abort;
  int            m_jv_eng;

  // emulated engines (random phase only)
  int            e_rem [N];
  logic [IW-1:0] e_base [N];
  logic [CW-1:0] e_cnt [N];
  bit            e_hit [N];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [N-1:0] m_busy_vec();
    logic [N-1:0] v = '0;
    for (int i = 0; i < N; i++) v[i] = m_busy[i];
    return v;
  endfunction

  function automatic void m_reset();
    m_state = 0; m_rr = N - 1; m_next = '0; m_limit = '0; m_chunk = '0; m_midx = '0;
    m_jb = '0; m_jc = '0; m_jobs = '0; m_found = 0; m_abort = 0; m_jv_eng = -1;
    for (int i = 0; i < N; i++) m_busy[i] = 0;
  endfunction

  // One clock of the scheduler rules, using the inputs presented during that clock.
  function automatic void m_step(input bit st, input bit ab, input logic [N-1:0] dn,
                                 input logic [N-1:0] mt, input logic [N*IW-1:0] ix);
    int hit = -1;
    int g = -1;
    bit any_busy = 0;
    logic [IW-1:0] cnt;
    m_jv_eng = -1;
    m_abort  = 0;
    for (int i = 0; i < N; i++) begin
      if (dn[i] && mt[i] && m_busy[i] && hit < 0) hit = i;
      if (m_busy[i]) any_busy = 1;
    end
    if (m_state == 1)
      for (int k = 1; k <= N; k++)
        if (g < 0 && !m_busy[(m_rr + k) % N]) g = (m_rr + k) % N;
    for (int i = 0; i < N; i++) if (dn[i]) m_busy[i] = 0;
    if (ab && m_state != 0) begin
      m_abort = 1; m_state = 0;
      for (int i = 0; i < N; i++) m_busy[i] = 0;
    end else if (m_state == 0 || m_state == 3 || m_state == 4) begin
      if (st) begin
        m_next = cfgBase; m_limit = cfgLimit;
        m_chunk = (cfgChunk == 0) ? 64'd1 : 64'(cfgChunk);
        m_found = 0; m_midx = '0; m_jobs = '0;
        m_state = (cfgBase >= cfgLimit) ? 4 : 1;
      end
    end else if (hit >= 0) begin
      m_found = 1; m_midx = ix[hit*IW +: IW]; m_abort = 1; m_state = 3;
      for (int i = 0; i < N; i++) m_busy[i] = 0;
    end else if (m_state == 1) begin
      if (g >= 0) begin
        cnt = (m_chunk < m_limit - m_next) ? m_chunk : m_limit - m_next;
        m_jv_eng = g; m_jb = m_next; m_jc = cnt[CW-1:0];
        m_busy[g] = 1; m_rr = g; m_next = m_next + cnt; m_jobs = m_jobs + 1;
        if (m_next == m_limit) m_state = 2;
      end
    end else if (!any_busy) begin
      m_state = 4;
    end
  endfunction

  task automatic compare_all();
    logic [N-1:0] ev = '0;
    if (m_jv_eng >= 0) ev[m_jv_eng] = 1'b1;
    chk("jobValid", 64'(jobValid), 64'(ev));
    if (m_jv_eng >= 0) begin
      chk("jobBase", jobBase, m_jb);
      chk("jobCount", 64'(jobCount), 64'(m_jc));
    end
    chk("abortAll", 64'(abortAll), 64'(m_abort));
    chk("busy", 64'(busy), 64'(m_busy_vec()));
    chk("state", 64'(state), 64'(m_state));
    chk("found", 64'(found), 64'(m_found));
    chk("matchIndex", matchIndex, m_midx);
    chk("jobsIssued", 64'(jobsIssued), 64'(m_jobs));
  endtask

  // Drive one clock of inputs, advance the model and compare everything.
  task automatic cycle(input bit st, input bit ab, input logic [N-1:0] dn,
                       input logic [N-1:0] mt, input logic [N*IW-1:0] ix);
    int drv = cyc;
    start = st; hostAbort = ab; engineDone = dn; engineMatch = mt; engineMatchIdx = ix;
    @(posedge clk); #1;
    cyc = drv + 1;
    m_step(st, ab, dn, mt, ix);
    if (jobValid != '0) jq.push_back('{jobValid, jobBase, jobCount, drv + 1});
    if (abortAll) n_abort_seen++;
    compare_all();
    start = 0; hostAbort = 0; engineDone = '0; engineMatch = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) cycle(0, 0, '0, '0, '0);
  endtask

  task automatic cfg(input logic [IW-1:0] b, input logic [IW-1:0] l, input logic [CW-1:0] c);
    cfgBase = b; cfgLimit = l; cfgChunk = c;
  endtask

  task automatic do_reset();
    reset_n = 0; start = 0; hostAbort = 0; engineDone = '0; engineMatch = '0;
    @(posedge clk); #1;
    m_reset();
    compare_all();
    @(posedge clk); #1;
    reset_n = 1;
    cyc += 2;
    for (int i = 0; i < N; i++) e_rem[i] = 0;
  endtask

  task automatic rand_cycle(input int hit_pct);
    logic [N-1:0] dn = '0, mt = '0;
    logic [N*IW-1:0] ix = '0;
    bit st = 0, ab = 0;
    int g;
    for (int i = 0; i < N; i++) begin
      ix[i*IW +: IW] = {$urandom, $urandom};
      if (e_rem[i] > 0) begin
        e_rem[i]--;
        if (e_rem[i] == 0) begin
          dn[i] = 1; mt[i] = e_hit[i];
          ix[i*IW +: IW] = e_base[i] + 64'($urandom_range(0, int'(e_cnt[i]) - 1));
        end else if ($urandom_range(0, 9) == 0) begin
          mt[i] = 1;  // match without done: must be ignored
        end
      end else if ($urandom_range(0, 19) == 0) begin
        dn[i] = 1'($urandom_range(0, 1)); mt[i] = 1;  // stray report from an idle engine
      end
    end
    if ((m_state == 1 || m_state == 2) && $urandom_range(0, 39) == 0) begin
      st = 1; cfgBase = {$urandom, $urandom};
    end
    if (m_state != 0 && $urandom_range(0, 299) == 0) ab = 1;
    cycle(st, ab, dn, mt, ix);
    if (m_abort) for (int i = 0; i < N; i++) e_rem[i] = 0;
    if (m_jv_eng >= 0) begin
      g = m_jv_eng;
      e_rem[g] = $urandom_range(1, 6); e_base[g] = m_jb; e_cnt[g] = m_jc;
      e_hit[g] = ($urandom_range(0, 99) < hit_pct);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int s, d, nj, rb;
    bit settled;
    logic [N*IW-1:0] ix;
    logic [N-1:0] ev [3];
    logic [IW-1:0] eb [3];
    logic [CW-1:0] ec [3];
    logic [IW-1:0] base, lim;

    do_reset();

    // basic split: 0..10 by 4
    jq.delete();
    cfg(0, 10, 4);
    s = cyc;
    cycle(1, 0, '0, '0, '0);
    idle(3);
    ev = '{4'b0001, 4'b0010, 4'b0100}; eb = '{0, 4, 8}; ec = '{4, 4, 2};
    chk("t1_njobs", 64'(jq.size()), 64'd3);
    for (int i = 0; i < 3 && i < jq.size(); i++) begin
      chk("t1_eng", 64'(jq[i].v), 64'(ev[i]));
      chk("t1_base", jq[i].b, eb[i]);
      chk("t1_cnt", 64'(jq[i].c), 64'(ec[i]));
      chk("t1_time", 64'(jq[i].t), 64'(s + 2 + i));
    end
    chk("t1_drain", 64'(state), 64'd2);
    cycle(0, 0, 4'b0111, '0, '0);
    idle(1);
    chk("t1_exhausted", 64'(state), 64'd4);
    chk("t1_jobs", 64'(jobsIssued), 64'd3);

    // empty range, then chunk of zero
    jq.delete();
    cfg(100, 100, 5);
    cycle(1, 0, '0, '0, '0);
    chk("t2_empty_state", 64'(state), 64'd4);
    chk("t2_empty_jobs", 64'(jobsIssued), 64'd0);
    idle(3);
    chk("t2_no_jobvalid", 64'(jq.size()), 64'd0);
    cfg(0, 3, 0);
    cycle(1, 0, '0, '0, '0);
    idle(3);
    chk("t2_njobs", 64'(jq.size()), 64'd3);
    for (int i = 0; i < 3 && i < jq.size(); i++) begin
      chk("t2_base", jq[i].b, 64'(i));
      chk("t2_cnt", 64'(jq[i].c), 64'd1);
    end
    cycle(0, 0, m_busy_vec(), '0, '0);
    idle(1);
    chk("t2_exhausted", 64'(state), 64'd4);

    // refill after done, then single hit
    do_reset();
    jq.delete();
    cfg(0, 64, 4);
    cycle(1, 0, '0, '0, '0);
    idle(4);
    chk("t3_allbusy", 64'(busy), 64'hF);
    d = cyc;
    cycle(0, 0, 4'b0010, '0, '0);
    idle(2);
    chk("t3_njobs", 64'(jq.size()), 64'd5);
    if (jq.size() > 0) begin
      chk("t3_refill_eng", 64'(jq[$].v), 64'b0010);
      chk("t3_refill_base", jq[$].b, 64'd16);
      chk("t3_refill_time", 64'(jq[$].t), 64'(d + 2));
    end
    ix = '0; ix[2*IW +: IW] = 64'h2A;
    n_abort_seen = 0;
    nj = jq.size();
    cycle(0, 0, 4'b0100, 4'b0100, ix);
    chk("t3_midx", matchIndex, 64'h2A);
    chk("t3_found", 64'(found), 64'd1);
    chk("t3_state", 64'(state), 64'd3);
    chk("t3_busy", 64'(busy), 64'd0);
    idle(4);
    chk("t3_abort_pulses", 64'(n_abort_seen), 64'd1);
    chk("t3_no_more_jobs", 64'(jq.size()), 64'(nj));

    // two hits in one cycle: lowest engine wins
    cfg(0, 64, 4);
    cycle(1, 0, '0, '0, '0);
    idle(4);
    ix = '0; ix[1*IW +: IW] = 64'h11; ix[3*IW +: IW] = 64'h33;
    cycle(0, 0, 4'b1010, 4'b1010, ix);
    chk("t4_midx", matchIndex, 64'h11);

    // host abort mid-dispatch
    cfg(0, 1000, 4);
    cycle(1, 0, '0, '0, '0);
    idle(2);
    cycle(0, 1, '0, '0, '0);
    chk("t5_state", 64'(state), 64'd0);
    chk("t5_abort", 64'(abortAll), 64'd1);
    chk("t5_busy", 64'(busy), 64'd0);
    chk("t5_jobs_kept", 64'(jobsIssued), 64'd2);
    idle(1);
    chk("t5_abort_once", 64'(abortAll), 64'd0);

    // asynchronous reset mid-job
    cfg(0, 1000, 4);
    cycle(1, 0, '0, '0, '0);
    idle(3);
    #3 reset_n = 0;
    #1;
    m_reset();
    compare_all();
    chk("t6_jobbase_async", jobBase, 64'd0);
    @(posedge clk); #1;
    reset_n = 1;
    cyc++;

    // randomized searches
    for (int i = 0; i < N; i++) e_rem[i] = 0;
    for (int it = 0; it < 30; it++) begin
      if (m_state == 1 || m_state == 2) rand_cycle(0);
      if (m_state == 1 || m_state == 2) begin
        cycle(0, 1, '0, '0, '0);
        for (int i = 0; i < N; i++) e_rem[i] = 0;
      end
      if (it % 5 == 4) base = 64'hFFFF_FFFF_FFFF_FF00 + 64'($urandom_range(0, 128));
      else             base = 64'($urandom);
      rb  = $urandom_range(0, 60);
      lim = (it % 7 == 3) ? base - 64'd5 : base + 64'(rb);
      cfg(base, lim, CW'($urandom_range(0, 9)));
      cycle(1, 0, '0, '0, '0);
      settled = (m_state == 0 || m_state == 3 || m_state == 4);
      for (int k = 0; k < 600 && !settled; k++) begin
        rand_cycle((it % 3 == 0) ? 0 : 15);
        settled = (m_state == 0 || m_state == 3 || m_state == 4);
      end
      chk("rand_settle", 64'(settled), 64'd1);
      idle(2);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
